// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - interrupt controller: sync/edge detect, mask, fixed priority, req/ack/eoi FSM, register window
module irq_sched #(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'd990
) (
    input  logic             MAX10_CLK1_50,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src,
    input  logic [15:0]      bus_addr,
    input  logic             bus_we,
    input  logic [7:0]       bus_din,
    output logic [7:0]       bus_dout,
    output logic             bus_hit,
    output logic             irq_req,
    output logic [7:0]       irq_vec,
    input  logic             irq_ack,
    input  logic             irq_eoi
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nx;
    logic [N_SRC-1:0] sync1, sync2, sync3;
    logic [N_SRC-1:0] mask, pend, mode, isr;
    logic [N_SRC-1:0] mask_nx, pend_nx, isr_nx;
    logic [N_SRC-1:0] eligible, set_bits, clr_bits, w1c_bits, vec_onehot;
    logic             en, en_nx, hit, any_elig, take_ack;
    logic [15:0]      off;
    logic [2:0]       win;
    logic [7:0]       vec_nx, rdata;

    function automatic logic [7:0] zext(input logic [N_SRC-1:0] v);
        zext = '0;
        zext[N_SRC-1:0] = v;
    endfunction

    assign off      = bus_addr - BASE_ADDR;
    assign hit      = (bus_addr >= BASE_ADDR) && (off < 16'd6);
    assign eligible = pend & mask;
    assign set_bits = sync2 & ~sync3;
    assign irq_req  = (state == REQ);

    always_comb begin
        mask_nx  = mask;
        en_nx    = en;
        w1c_bits = '0;
        if (bus_we && hit) begin
            case (off[2:0])
                3'd0:    mask_nx  = bus_din[N_SRC-1:0];
                3'd1:    w1c_bits = bus_din[N_SRC-1:0];
                3'd5:    en_nx    = bus_din[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win      = 3'(i);
                any_elig = 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) vec_onehot[i] = (irq_vec == 8'(i));
    end

    // Disable is judged on the post-write value so irq_req drops the cycle after the write.
    always_comb begin
        state_nx = state;
        vec_nx   = irq_vec;
        isr_nx   = isr;
        take_ack = 1'b0;
        case (state)
            IDLE: if (en && any_elig) begin
                vec_nx   = {5'd0, win};
                state_nx = REQ;
            end
            REQ: begin
                if (irq_ack) begin
                    take_ack = 1'b1;
                    isr_nx   = vec_onehot;
                    state_nx = SERVICE;
                end else if (!en_nx || ((mask_nx & vec_onehot) == '0)) begin
                    state_nx = IDLE;
                end
            end
            SERVICE: if (irq_eoi) begin
                isr_nx   = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Edge-mode set beats any clear in the same cycle; level mode simply tracks the synced line.
    assign clr_bits = w1c_bits | (take_ack ? vec_onehot : '0);
    assign pend_nx  = (mode & (set_bits | (pend & ~clr_bits))) | (~mode & sync2);

    always_comb begin
        rdata = 8'd0;
        case (off[2:0])
            3'd0:    rdata = zext(mask);
            3'd1:    rdata = zext(pend);
            3'd2:    rdata = zext(mode);
            3'd3:    rdata = zext(isr);
            3'd4:    rdata = irq_vec;
            3'd5:    rdata = {7'd0, en};
            default: rdata = 8'd0;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            mask     <= '0;
            pend     <= '0;
            mode     <= '0;
            isr      <= '0;
            en       <= 1'b0;
            irq_vec  <= 8'd0;
            bus_dout <= 8'd0;
            bus_hit  <= 1'b0;
        end else begin
            state    <= state_nx;
            sync1    <= src;
            sync2    <= sync1;
            sync3    <= sync2;
            mask     <= mask_nx;
            en       <= en_nx;
            pend     <= pend_nx;
            isr      <= isr_nx;
            irq_vec  <= vec_nx;
            if (bus_we && hit && off[2:0] == 3'd2) mode <= bus_din[N_SRC-1:0];
            bus_hit  <= hit;
            bus_dout <= hit ? rdata : 8'd0;
        end
    end
endmodule
